// File: rtl/serial_full_adder.sv
// Digit-serial adder/subtractor: DIGIT full-adder cells rippled per clock, LSB first,
// with a start/busy/done handshake and registered sum/cout/ovf.

module sfa_cell (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_full_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int STEPS = WIDTH / DIGIT;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic [DIGIT:0]   w_c;
   logic [DIGIT-1:0] w_dsum;
   logic [WIDTH-1:0] w_a_next;

   assign w_c[0] = r_carry;

   for (genvar gi = 0; gi < DIGIT; gi++) begin : g_cell
      sfa_cell u_cell (
         .i_a (r_a[gi]),
         .i_b (r_b[gi]),
         .i_c (w_c[gi]),
         .o_s (w_dsum[gi]),
         .o_c (w_c[gi+1])
      );
   end

   // Operand A doubles as the result register: consumed bits leave at the LSB end
   // while freshly computed digits enter at the MSB end.
   if (DIGIT == WIDTH) begin : g_whole
      assign w_a_next = w_dsum;
   end else begin : g_shift
      assign w_a_next = {w_dsum, r_a[WIDTH-1:DIGIT]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= sub ? ~b : b;
                  r_carry <= sub ? 1'b1 : cin;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_a     <= w_a_next;
               r_b     <= r_b >> DIGIT;
               r_carry <= w_c[DIGIT];
               r_cnt   <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST) begin
                  r_sum   <= w_a_next;
                  r_cout  <= w_c[DIGIT];
                  r_ovf   <= w_c[DIGIT] ^ w_c[DIGIT-1];
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_full_adder.sv
// Bench for serial_full_adder: three configurations (8x1, 8x4, 1x1) sharing inputs,
// checked against an integer-arithmetic reference model.

module tb_serial_full_adder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, sub, cin;
   logic [7:0] a, b;

   logic       busy0, done0, cout0, ovf0;
   logic [7:0] sum0;
   logic       busy1, done1, cout1, ovf1;
   logic [7:0] sum1;
   logic       busy2, done2, cout2, ovf2;
   logic [0:0] sum2;

   int n_checks = 0;
   int n_fail   = 0;

   serial_full_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0));

   serial_full_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));

   serial_full_adder #(.WIDTH(1), .DIGIT(1)) u_w1d1 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a[0:0]), .b(b[0:0]), .cin(cin),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

   function automatic logic f_busy(input int sel);
      case (sel)
         0:       return busy0;
         1:       return busy1;
         default: return busy2;
      endcase
   endfunction

   function automatic logic f_done(input int sel);
      case (sel)
         0:       return done0;
         1:       return done1;
         default: return done2;
      endcase
   endfunction

   function automatic logic [7:0] f_sum(input int sel);
      case (sel)
         0:       return sum0;
         1:       return sum1;
         default: return {7'b0, sum2};
      endcase
   endfunction

   function automatic logic f_cout(input int sel);
      case (sel)
         0:       return cout0;
         1:       return cout1;
         default: return cout2;
      endcase
   endfunction

   function automatic logic f_ovf(input int sel);
      case (sel)
         0:       return ovf0;
         1:       return ovf1;
         default: return ovf2;
      endcase
   endfunction

   // Reference: plain unsigned and signed integer arithmetic on w-bit operands.
   function automatic void model(input int w, input logic [7:0] ia, input logic [7:0] ib,
                                 input logic isub, input logic icin,
                                 output logic [7:0] s, output logic co, output logic ov);
      int m, ua, ub, sa, sb, r, rs;
      m  = 1 << w;
      ua = int'(ia) & (m - 1);
      ub = int'(ib) & (m - 1);
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      if (isub) begin
         r  = ua - ub;
         co = (ua >= ub);
         rs = sa - sb;
      end else begin
         r  = ua + ub + int'(icin);
         co = (r >= m);
         rs = sa + sb + int'(icin);
      end
      s  = 8'((r + m) % m);
      ov = (rs > m / 2 - 1) || (rs < -(m / 2));
   endfunction

   task automatic wait_idle();
      int guard = 0;
      while ((busy0 | busy1 | busy2 | done0 | done1 | done2) && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
   endtask

   // Stimulus driver: issues one start, optionally scrambles inputs while busy,
   // returns the captured result, busy cycle count and post-done activity.
   task automatic run_op(input int sel, input logic [7:0] ia, input logic [7:0] ib,
                         input logic isub, input logic icin, input logic toggle,
                         output logic [7:0] os, output logic oco, output logic oov,
                         output int nbusy, output int nextra, output logic tmo);
      wait_idle();
      a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      nbusy = 0;
      tmo   = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (f_done(sel)) begin
            tmo = 1'b0;
            break;
         end
         if (f_busy(sel)) nbusy++;
         if (toggle) begin
            a = 8'($urandom); b = 8'($urandom);
            sub = 1'($urandom); cin = 1'($urandom); start = 1'($urandom);
         end
         @(posedge clk); #1;
      end
      os  = f_sum(sel);
      oco = f_cout(sel);
      oov = f_ovf(sel);
      start = toggle;
      @(posedge clk); #1;
      nextra = int'(f_done(sel)) + int'(f_busy(sel));
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = 8'h00; b = 8'h00;
      #1;
      n_checks++;
      if ({busy0, done0, sum0, cout0, ovf0} !== 12'h000) begin
         n_fail++; $display("FAIL reset_w8d1: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0", busy0, done0, sum0, cout0, ovf0);
      end
      n_checks++;
      if ({busy1, done1, sum1, cout1, ovf1} !== 12'h000) begin
         n_fail++; $display("FAIL reset_w8d4: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0", busy1, done1, sum1, cout1, ovf1);
      end
      n_checks++;
      if ({busy2, done2, sum2, cout2, ovf2} !== 5'b00000) begin
         n_fail++; $display("FAIL reset_w1d1: got busy=%b done=%b sum=%b cout=%b ovf=%b, want all 0", busy2, done2, sum2, cout2, ovf2);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [7:0] s; logic co, ov, tmo; int nb, nx;
      run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, s, co, ov, nb, nx, tmo);
      n_checks++;
      if (tmo !== 1'b0 || s !== 8'h80 || co !== 1'b0 || ov !== 1'b1) begin
         n_fail++; $display("FAIL add_7F_01: got tmo=%b sum=%h cout=%b ovf=%b, want 0 80 0 1", tmo, s, co, ov);
      end
      n_checks++;
      if (nb !== 8 || nx !== 0) begin
         n_fail++; $display("FAIL add_7F_01_handshake: got busy_cycles=%0d extra=%0d, want 8 0", nb, nx);
      end
      run_op(0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, s, co, ov, nb, nx, tmo);
      n_checks++;
      if (tmo !== 1'b0 || s !== 8'h00 || co !== 1'b1 || ov !== 1'b0) begin
         n_fail++; $display("FAIL add_FF_00_c1: got tmo=%b sum=%h cout=%b ovf=%b, want 0 00 1 0", tmo, s, co, ov);
      end
      run_op(0, 8'h05, 8'h07, 1'b1, 1'b0, 1'b0, s, co, ov, nb, nx, tmo);
      n_checks++;
      if (tmo !== 1'b0 || s !== 8'hFE || co !== 1'b0 || ov !== 1'b0) begin
         n_fail++; $display("FAIL sub_05_07: got tmo=%b sum=%h cout=%b ovf=%b, want 0 FE 0 0", tmo, s, co, ov);
      end
   endtask

   task automatic test_run_toggle();
      logic [7:0] s; logic co, ov, tmo; int nb, nx;
      run_op(0, 8'h80, 8'h01, 1'b1, 1'b0, 1'b1, s, co, ov, nb, nx, tmo);
      n_checks++;
      if (tmo !== 1'b0 || s !== 8'h7F || co !== 1'b1 || ov !== 1'b1) begin
         n_fail++; $display("FAIL sub_80_01_toggled: got tmo=%b sum=%h cout=%b ovf=%b, want 0 7F 1 1", tmo, s, co, ov);
      end
      n_checks++;
      if (nb !== 8 || nx !== 0) begin
         n_fail++; $display("FAIL toggle_no_restart: got busy_cycles=%0d extra=%0d, want 8 0", nb, nx);
      end
   endtask

   task automatic test_reset_abort();
      logic [7:0] s, es; logic co, ov, tmo, eco, eov; int nb, nx, ndone;
      wait_idle();
      a = 8'h12; b = 8'h34; sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy0, done0, sum0, cout0, ovf0} !== 12'h000) begin
         n_fail++; $display("FAIL abort_clears: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0", busy0, done0, sum0, cout0, ovf0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (12) begin
         @(posedge clk); #1;
         ndone += int'(done0) + int'(busy0);
      end
      n_checks++;
      if (ndone !== 0) begin
         n_fail++; $display("FAIL abort_no_done: got activity=%0d, want 0", ndone);
      end
      model(8, 8'h12, 8'h34, 1'b0, 1'b0, es, eco, eov);
      run_op(0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, s, co, ov, nb, nx, tmo);
      n_checks++;
      if (tmo !== 1'b0 || s !== es || co !== eco || ov !== eov) begin
         n_fail++; $display("FAIL after_abort: got tmo=%b sum=%h cout=%b ovf=%b, want 0 %h %b %b", tmo, s, co, ov, es, eco, eov);
      end
   endtask

   task automatic test_digit4();
      logic [7:0] s; logic co, ov, tmo; int nb, nx;
      run_op(1, 8'h9C, 8'h64, 1'b0, 1'b0, 1'b0, s, co, ov, nb, nx, tmo);
      n_checks++;
      if (tmo !== 1'b0 || s !== 8'h00 || co !== 1'b1 || ov !== 1'b0) begin
         n_fail++; $display("FAIL d4_9C_64: got tmo=%b sum=%h cout=%b ovf=%b, want 0 00 1 0", tmo, s, co, ov);
      end
      n_checks++;
      if (nb !== 2 || nx !== 0) begin
         n_fail++; $display("FAIL d4_handshake: got busy_cycles=%0d extra=%0d, want 2 0", nb, nx);
      end
   endtask

   task automatic test_width1();
      logic [7:0] s; logic co, ov, tmo; int nb, nx;
      logic ta, tb, tc;
      for (int i = 0; i < 8; i++) begin
         ta = 1'(i >> 2); tb = 1'(i >> 1); tc = 1'(i);
         run_op(2, {7'b0, ta}, {7'b0, tb}, 1'b0, tc, 1'b0, s, co, ov, nb, nx, tmo);
         n_checks++;
         if (tmo !== 1'b0 || s[0] !== (ta ^ tb ^ tc) || co !== ((ta & tb) | (ta & tc) | (tb & tc)) || nb !== 1) begin
            n_fail++; $display("FAIL w1_abc_%0d: got tmo=%b sum=%b cout=%b busy_cycles=%0d, want 0 %b %b 1",
                               i, tmo, s[0], co, nb, ta ^ tb ^ tc, (ta & tb) | (ta & tc) | (tb & tc));
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] s, es, ra, rb; logic co, ov, tmo, eco, eov, rs, rc; int nb, nx, sel, w;
      for (int i = 0; i < 36; i++) begin
         sel = (i < 16) ? 0 : (i < 28) ? 1 : 2;
         w   = (sel == 2) ? 1 : 8;
         ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rc = 1'($urandom);
         if (sel == 2) begin
            ra = ra & 8'h01; rb = rb & 8'h01;
         end
         model(w, ra, rb, rs, rc, es, eco, eov);
         run_op(sel, ra, rb, rs, rc, 1'b0, s, co, ov, nb, nx, tmo);
         n_checks++;
         if (tmo !== 1'b0 || s !== es || co !== eco || ov !== eov || nx !== 0) begin
            n_fail++; $display("FAIL rand_%0d cfg%0d a=%h b=%h sub=%b cin=%b: got tmo=%b sum=%h cout=%b ovf=%b extra=%0d, want 0 %h %b %b 0",
                               i, sel, ra, rb, rs, rc, tmo, s, co, ov, nx, es, eco, eov);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] es, ra, rb; logic eco, eov, rc;
      int dcyc[$];
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      model(8, ra, rb, 1'b0, rc, es, eco, eov);
      wait_idle();
      a = ra; b = rb; sub = 1'b0; cin = rc; start = 1'b1;
      for (int cyc = 0; cyc < 35; cyc++) begin
         @(posedge clk); #1;
         if (done0) begin
            dcyc.push_back(cyc);
            n_checks++;
            if (sum0 !== es || cout0 !== eco || ovf0 !== eov) begin
               n_fail++; $display("FAIL b2b_result cyc%0d: got sum=%h cout=%b ovf=%b, want %h %b %b", cyc, sum0, cout0, ovf0, es, eco, eov);
            end
         end
      end
      start = 1'b0;
      n_checks++;
      if (dcyc.size() !== 3) begin
         n_fail++; $display("FAIL b2b_count: got %0d done pulses, want 3", dcyc.size());
      end else begin
         n_checks++;
         if (dcyc[0] !== 8 || dcyc[1] - dcyc[0] !== 10 || dcyc[2] - dcyc[1] !== 10) begin
            n_fail++; $display("FAIL b2b_spacing: got done at %0d %0d %0d, want 8 18 28", dcyc[0], dcyc[1], dcyc[2]);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
      test_run_toggle();
      test_reset_abort();
      test_digit4();
      test_width1();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
